// File: rtl/lc3_mem_arbiter.sv
// ---------------------------------------------------------------------------
// lc3_mem_arbiter
//
// Purpose:
//   Shares a single-port memory between the LC-3 datapath (MAR/MDR side) and
//   a debug/loader port. Each access follows the same sequence:
//     IDLE   - pick one requester and latch its we/addr/wdata into the
//              memory-side registers.
//     ACCESS - hold the access for WAIT_CYCLES+1 cycles.
//     DONE   - pulse the winner's ready for exactly one cycle.
//   The CPU-side ready (cpu_r) is the R input that the control FSM polls in
//   its memory wait states.
//
// Parameters:
//   WAIT_CYCLES  extra memory wait states per access, 0..15
//   ADDR_W       address width
//   DATA_W       data width
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   cpu_req/we/addr/wdata           CPU request, held until cpu_r
//   cpu_rdata, cpu_r                CPU read data and one-cycle ready
//   dbg_req/we/addr/wdata           debug request, held until dbg_ack
//   dbg_rdata, dbg_ack              debug read data and one-cycle ready
//   mem_en/we/addr/wdata, mem_rdata memory array interface
//   grant_dbg                       1 while debug owns the current/last access
//
// Configuration:
//   LC3_ARB_ROUND_ROBIN_EN  When defined, contention goes to the port that
//                           was not granted last. When undefined, the CPU
//                           always wins contention.
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module lc3_mem_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_r,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t              state_q,     state_d;
  logic [3:0]          cnt_q,       cnt_d;
  logic                mem_en_q,    mem_en_d;
  logic                mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
  logic                cpu_r_q,     cpu_r_d;
  logic                dbg_ack_q,   dbg_ack_d;
  // Owner of the current/last access. In round-robin builds this register is
  // also the last-grant state, since both update together on every grant.
  logic                grant_dbg_q, grant_dbg_d;

  // Winner selection, only used when at least one request is present.
  logic pick_dbg;

`ifdef LC3_ARB_ROUND_ROBIN_EN
  always_comb begin
    if (cpu_req && dbg_req) begin
      pick_dbg = !grant_dbg_q;
    end else begin
      pick_dbg = dbg_req;
    end
  end
`else
  assign pick_dbg = dbg_req && !cpu_req;
`endif

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case statement can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    grant_dbg_d = grant_dbg_q;
    cpu_r_d     = 1'b0;
    dbg_ack_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
        if (cpu_req || dbg_req) begin
          grant_dbg_d = pick_dbg;
          mem_en_d    = 1'b1;
          mem_we_d    = pick_dbg ? dbg_we    : cpu_we;
          mem_addr_d  = pick_dbg ? dbg_addr  : cpu_addr;
          mem_wdata_d = pick_dbg ? dbg_wdata : cpu_wdata;
          cnt_d       = WAIT_INIT;
          state_d     = S_ACCESS;
        end
      end

      S_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Final access cycle: read data is valid now. Writes leave the
          // rdata registers holding the previous read.
          if (!mem_we_q) begin
            if (grant_dbg_q) dbg_rdata_d = mem_rdata;
            else             cpu_rdata_d = mem_rdata;
          end
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          // The ready flop is set on this edge so that it reads high for
          // exactly the DONE cycle.
          if (grant_dbg_q) dbg_ack_d = 1'b1;
          else             cpu_r_d   = 1'b1;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d  = S_IDLE;
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the values computed before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      cpu_r_q     <= 1'b0;
      dbg_ack_q   <= 1'b0;
      grant_dbg_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      cpu_r_q     <= cpu_r_d;
      dbg_ack_q   <= dbg_ack_d;
      grant_dbg_q <= grant_dbg_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign cpu_r     = cpu_r_q;
  assign dbg_ack   = dbg_ack_q;
  assign grant_dbg = grant_dbg_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lc3_mem_arbiter
//
// Purpose:
//   Self-checking bench for lc3_mem_arbiter. Drives a table of single-port
//   accesses plus hand-written contention, reset-abort and zero-wait-state
//   sequences. Every expected ready is queued as a scoreboard entry when its
//   request is driven. A monitor pops the entry when a ready pulse appears
//   and checks the port, the cycle, both rdata registers and grant_dbg.
//
// Instances:
//   u_dut   WAIT_CYCLES=2, connected to a 64K x 16 memory model
//   u_dut0  WAIT_CYCLES=0, read data = address ^ 16'h5A5A
// ---------------------------------------------------------------------------
module tb_lc3_mem_arbiter;

`ifdef LC3_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic [15:0] cpu_rdata, dbg_rdata;
  logic        cpu_r, dbg_ack;
  logic        mem_en, mem_we, grant_dbg;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  // Signals for the zero-wait-state instance.
  logic        cpu_req0;
  logic [15:0] cpu_addr0;
  logic [15:0] cpu_rdata0, dbg_rdata0, mem_addr0, mem_wdata0, mem_rdata0;
  logic        cpu_r0, dbg_ack0, mem_en0, mem_we0, grant_dbg0;

  logic [15:0] mem [65536];

  always #5 clk = ~clk;

  lc3_mem_arbiter #(.WAIT_CYCLES(W), .ADDR_W(16), .DATA_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_r(cpu_r),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .grant_dbg(grant_dbg)
  );

  lc3_mem_arbiter #(.WAIT_CYCLES(0), .ADDR_W(16), .DATA_W(16)) u_dut0 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req0), .cpu_we(1'b0), .cpu_addr(cpu_addr0), .cpu_wdata(16'h0000),
    .cpu_rdata(cpu_rdata0), .cpu_r(cpu_r0),
    .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(16'h0000), .dbg_wdata(16'h0000),
    .dbg_rdata(dbg_rdata0), .dbg_ack(dbg_ack0),
    .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .mem_rdata(mem_rdata0), .grant_dbg(grant_dbg0)
  );

  // Memory models
  assign mem_rdata  = mem[mem_addr];
  assign mem_rdata0 = mem_addr0 ^ 16'h5A5A;

  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Check bookkeeping
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard
  typedef struct {
    logic        dbg;
    int          due;
    logic [15:0] cpu_rd;
    logic [15:0] dbg_rd;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] last_rd [2];
  logic        last_dbg_m;

  task automatic push(input logic dbg, input logic we, input logic [15:0] rdata, input int due);
    exp_t e;
    if (!we) last_rd[int'(dbg)] = rdata;
    e.dbg    = dbg;
    e.due    = due;
    e.cpu_rd = last_rd[0];
    e.dbg_rd = last_rd[1];
    last_dbg_m = dbg;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (cpu_r || dbg_ack) begin
      if (cpu_r && dbg_ack) begin
        check("both_ready", 32'(dbg_ack), 32'(1'b0));
      end else if (sb_q.size() == 0) begin
        check("unexpected_ready", {30'd0, dbg_ack, cpu_r}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("ready_port",  32'(dbg_ack),   32'(e.dbg));
        check("ready_cycle", 32'(cyc),       32'(e.due));
        check("cpu_rdata",   32'(cpu_rdata), 32'(e.cpu_rd));
        check("dbg_rdata",   32'(dbg_rdata), 32'(e.dbg_rd));
        check("grant_dbg",   32'(grant_dbg), 32'(e.dbg));
      end
    end
  end

  // Stimulus helpers
  typedef struct {
    logic        dbg;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } vec_t;

  task automatic drive_port(input logic dbg, input logic req, input logic we,
                            input logic [15:0] addr, input logic [15:0] wdata);
    if (dbg) begin
      dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
    end else begin
      cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
  endtask

  // Starts in an IDLE cycle; returns in the IDLE cycle after DONE.
  // Port inputs are scrambled after the grant and must be ignored.
  task automatic do_access(input vec_t v);
    int n;
    n = cyc;
    drive_port(v.dbg, 1'b1, v.we, v.addr, v.wdata);
    push(v.dbg, v.we, v.rdata, n + W + 2);
    @(negedge clk);
    drive_port(v.dbg, 1'b1, ~v.we, ~v.addr, ~v.wdata);
    repeat (W + 1) @(negedge clk);
    drive_port(v.dbg, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clk);
    check("grant_hold_idle", 32'(grant_dbg), 32'(v.dbg));
  endtask

  function automatic logic rr_winner(input logic last);
    return RR ? !last : 1'b0;
  endfunction

  vec_t vecs [9];

  initial begin
    logic w;
    int   n;

    vecs[0] = '{dbg: 1'b1, we: 1'b1, addr: 16'h4000, wdata: 16'hBEEF, rdata: 16'h0000};
    vecs[1] = '{dbg: 1'b0, we: 1'b0, addr: 16'h4000, wdata: 16'h0000, rdata: 16'hBEEF};
    vecs[2] = '{dbg: 1'b0, we: 1'b0, addr: 16'h3000, wdata: 16'h0000, rdata: 16'h1234};
    vecs[3] = '{dbg: 1'b0, we: 1'b1, addr: 16'h3001, wdata: 16'h5555, rdata: 16'h0000};
    vecs[4] = '{dbg: 1'b1, we: 1'b0, addr: 16'h3001, wdata: 16'h0000, rdata: 16'h5555};
    vecs[5] = '{dbg: 1'b1, we: 1'b0, addr: 16'hFFFF, wdata: 16'h0000, rdata: 16'h5A5A};
    vecs[6] = '{dbg: 1'b0, we: 1'b1, addr: 16'h0000, wdata: 16'hFFFF, rdata: 16'h0000};
    vecs[7] = '{dbg: 1'b0, we: 1'b0, addr: 16'h0000, wdata: 16'h0000, rdata: 16'hFFFF};
    vecs[8] = '{dbg: 1'b1, we: 1'b0, addr: 16'h3000, wdata: 16'h0000, rdata: 16'h1234};

    for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'hA5A5;
    mem[16'h3000] = 16'h1234;

    last_rd[0] = 16'h0000;
    last_rd[1] = 16'h0000;
    last_dbg_m = 1'b0;

    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    cpu_req0 = 1'b0; cpu_addr0 = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_mem_en",    32'(mem_en),    32'd0);
    check("rst_mem_we",    32'(mem_we),    32'd0);
    check("rst_mem_addr",  32'(mem_addr),  32'd0);
    check("rst_cpu_r",     32'(cpu_r),     32'd0);
    check("rst_dbg_ack",   32'(dbg_ack),   32'd0);
    check("rst_grant_dbg", 32'(grant_dbg), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single-requester vector table
    for (int i = 0; i < 9; i++) do_access(vecs[i]);

    // One contention: the loser waits and is served after one IDLE cycle.
    n = cyc;
    w = rr_winner(last_dbg_m);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h4000;
    push(w,  1'b0, w  ? 16'hBEEF : 16'h1234, n + W + 2);
    push(!w, 1'b0, !w ? 16'hBEEF : 16'h1234, n + 2 * (W + 2) + 1);
    repeat (W + 2) @(negedge clk);
    if (w) dbg_req = 1'b0; else cpu_req = 1'b0;
    repeat (W + 3) @(negedge clk);
    cpu_req = 1'b0; dbg_req = 1'b0;
    @(negedge clk);

    // Both requests held across four back-to-back accesses.
    n = cyc;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3001;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      w = rr_winner(last_dbg_m);
      push(w, 1'b0, w ? 16'h5A5A : 16'h5555, n + W + 2 + i * (W + 3));
    end
    repeat (W + 2 + 3 * (W + 3)) @(negedge clk);
    cpu_req = 1'b0; dbg_req = 1'b0;
    @(negedge clk);

    // Reset during the ACCESS phase of a write: no ready pulse may follow.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h5000; cpu_wdata = 16'hAAAA;
    @(negedge clk);
    check("abort_mem_en_before",   32'(mem_en),   32'd1);
    check("abort_mem_we_before",   32'(mem_we),   32'd1);
    check("abort_mem_addr_before", 32'(mem_addr), 32'h5000);
    @(negedge clk);
    rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    check("abort_mem_en",    32'(mem_en),    32'd0);
    check("abort_mem_we",    32'(mem_we),    32'd0);
    check("abort_cpu_r",     32'(cpu_r),     32'd0);
    check("abort_grant_dbg", 32'(grant_dbg), 32'd0);
    rst = 1'b0;
    last_dbg_m = 1'b0;
    last_rd[0] = 16'h0000;
    last_rd[1] = 16'h0000;
    repeat (3) @(negedge clk);
    check("abort_no_late_ready", 32'(cpu_r), 32'd0);
    do_access('{dbg: 1'b0, we: 1'b1, addr: 16'h5000, wdata: 16'h1357, rdata: 16'h0000});
    do_access('{dbg: 1'b0, we: 1'b0, addr: 16'h5000, wdata: 16'h0000, rdata: 16'h1357});

    // Zero wait states; request dropped one cycle after being sampled.
    cpu_req0 = 1'b1; cpu_addr0 = 16'h3000;
    @(negedge clk);
    check("w0_cpu_r_n1", 32'(cpu_r0), 32'd0);
    cpu_req0 = 1'b0; cpu_addr0 = 16'h0000;
    @(negedge clk);
    check("w0_cpu_r_n2",   32'(cpu_r0),     32'd1);
    check("w0_cpu_rdata",  32'(cpu_rdata0), 32'h6A5A);
    @(negedge clk);
    check("w0_cpu_r_n3",   32'(cpu_r0),     32'd0);
    check("w0_mem_en_n3",  32'(mem_en0),    32'd0);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
